mor1kx_icache_refill_ctrl: RTL and testbench
============================================

# mor1kx_icache_refill_ctrl

Bus-master sequencer that services instruction-cache line refills. It accepts a miss request from the icache, issues a Wishbone B3 wrapped burst for the missing line, and streams each returned word into the cache write port (address, data, write strobe). It reports bus errors and timeouts back to the cache as an imem error. It sits between the icache and the instruction bus bridge.

## Interface
Parameters:
- OPTION_OPERAND_WIDTH, 32, data and address width.
- OPTION_ICACHE_BLOCK_WIDTH, 5, log2 line bytes; only 4 (16 B, 4 beats) and 5 (32 B, 8 beats) are legal.
- TIMEOUT_CYCLES, 255, maximum cycles without ack before abort; 8-bit counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- refill_req_i  in  1  cache requests a refill; sampled only in IDLE.
- req_adr_i  in  32  miss address; bits [1:0] ignored.
- wradr_o  in→out  32  cache write address (output).
- wrdat_o  out  32  cache write data.
- we_o  out  1  cache write strobe.
- err_o  out  1  one-cycle bus error/timeout pulse; drives the cache imem error input.
- busy_o  out  1  high in BURST and DONE.
- bus_adr_o  out  32  Wishbone address.
- bus_cyc_o, bus_stb_o  out  1 each  Wishbone cycle/strobe.
- bus_cti_o  out  3  3'b010 on non-final beats, 3'b111 on the final beat.
- bus_bte_o  out  2  burst type extension.
- bus_dat_i  in  32  read data.
- bus_ack_i, bus_err_i  in  1 each  Wishbone ack/error.

## Operation
- States: IDLE, BURST, DONE.
- IDLE → BURST when refill_req_i=1.
  - Latch the start address: with CWF, {req_adr_i[31:2],2'b00}; without CWF, line-aligned.
  - Clear the beat counter and the timeout counter.
- BURST:
  - cyc, stb and wradr_o are asserted from the registered address.
  - On bus_ack_i & !bus_err_i:
    - we_o=1 and wrdat_o=bus_dat_i in the same cycle (combinational pass-through).
    - Address bits [BLOCK_WIDTH-1:2] increment modulo the line size; upper bits are held.
    - The beat counter increments.
    - The timeout counter clears.
  - Ack on the final beat (count = beats-1) → DONE.
- DONE: cyc and stb low for one cycle; refill_req_i is ignored; then → IDLE. This guard covers the cache's final REFILL cycle.
- bus_err_i in BURST (wins over a simultaneous ack):
  - No write.
  - err_o=1 for the next cycle.
  - cyc and stb drop next cycle.
  - → IDLE.
- Timeout: the counter increments each BURST cycle without ack. When it reaches TIMEOUT_CYCLES, the block behaves exactly as on bus_err_i.
- Deassertion of refill_req_i mid-burst is ignored; the line always completes.
- Reset values: state IDLE; all outputs 0, except wradr_o, which equals the registered address and resets to 0.

## Timing
- Request-to-bus latency: cyc and stb assert one cycle after refill_req_i is sampled in IDLE.
- Zero-wait-state slave: one word per cycle; a line takes beats+2 cycles from request to IDLE.
- we_o is combinational from bus_ack_i and must not be registered.
- The address advances on the clock edge after each ack.
- bus_cti_o=3'b111 is set while the counter equals beats-1.
- rst mid-burst: cyc and stb are low on the cycle after rst; no err_o pulse.

## Configuration
- MOR1KX_ICACHE_REFILL_CWF_EN defined (critical word first):
  - The burst starts at the missed word and wraps within the line.
  - bus_bte_o = 2'b01 for 16 B lines, 2'b10 for 32 B lines.
- Undefined:
  - The burst starts at the line base with linear increment; bus_bte_o=2'b00.
  - The address never wraps because exactly one line of beats is issued.

## Test plan
- BLOCK_WIDTH=5, CWF on, req_adr_i=0x1014, zero-wait ack → bus_adr_o 0x1014, 0x1018, 0x101C, 0x1000 … 0x1010.
  - Eight we_o pulses.
  - cti 010×7 then 111.
  - bte=10.
  - busy_o drops after 10 cycles.
- CWF off, req_adr_i=0x1014 → addresses 0x1000…0x101C ascending; bte=00.
- Ack every other cycle, BLOCK_WIDTH=4 → four writes with wrdat_o matching bus_dat_i; no write in non-ack cycles.
- bus_err_i on the third beat → exactly two we_o pulses; err_o high one cycle; cyc low next cycle; state IDLE.
- TIMEOUT_CYCLES=255, no ack ever → err_o after 255 BURST cycles; no we_o.
- rst asserted on the second beat → cyc/stb/we_o low the next cycle; refill_req_i=1 afterwards starts a fresh burst at the new req_adr_i.

Source files
------------

// File: rtl/mor1kx_icache_refill_ctrl.sv
// Instruction-cache line refill sequencer: issues one Wishbone B3 burst per miss and streams words into the cache.
// Define MOR1KX_ICACHE_REFILL_CWF_EN for critical-word-first wrapped bursts; otherwise line-base linear bursts.
module mor1kx_icache_refill_ctrl #(
    parameter int OPTION_OPERAND_WIDTH      = 32,
    parameter int OPTION_ICACHE_BLOCK_WIDTH = 5,
    parameter int TIMEOUT_CYCLES            = 255
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            refill_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] req_adr_i,

    output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wrdat_o,
    output logic                            we_o,
    output logic                            err_o,
    output logic                            busy_o,

    output logic [OPTION_OPERAND_WIDTH-1:0] bus_adr_o,
    output logic                            bus_cyc_o,
    output logic                            bus_stb_o,
    output logic [2:0]                      bus_cti_o,
    output logic [1:0]                      bus_bte_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] bus_dat_i,
    input  logic                            bus_ack_i,
    input  logic                            bus_err_i
);

    localparam int W  = OPTION_OPERAND_WIDTH;
    localparam int BW = OPTION_ICACHE_BLOCK_WIDTH;
    localparam int IW = BW - 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [2:0] LAST_BEAT = 3'((1 << IW) - 1);
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);

`ifdef MOR1KX_ICACHE_REFILL_CWF_EN
    localparam logic [1:0] BURST_BTE = (BW == 4) ? 2'b01 : 2'b10;
`else
    localparam logic [1:0] BURST_BTE = 2'b00;
`endif

    logic [1:0]   state_q, state_d;
    logic [W-1:0] addr_q, addr_d;
    logic [2:0]   beat_q, beat_d;
    logic [7:0]   tmo_q, tmo_d;
    logic         err_q, err_d;

    logic         in_burst;
    logic         ack_ok;
    logic         abort;
    logic         last_beat;
    logic [IW-1:0] idx_next;
    logic [W-1:0] start_adr;
    logic         unused_adr_bits;

    assign in_burst  = (state_q == BURST);
    assign last_beat = (beat_q == LAST_BEAT);
    assign ack_ok    = in_burst & bus_ack_i & ~bus_err_i;
    // A timeout is only declared on a cycle that also lacks an ack, so a late ack still lands.
    assign abort     = in_burst & (bus_err_i | (~bus_ack_i & (tmo_q == TMO_LAST)));
    assign idx_next  = addr_q[BW-1:2] + IW'(1);

`ifdef MOR1KX_ICACHE_REFILL_CWF_EN
    assign start_adr = {req_adr_i[W-1:2], 2'b00};
`else
    assign start_adr = {req_adr_i[W-1:BW], {BW{1'b0}}};
`endif
    assign unused_adr_bits = ^req_adr_i[BW-1:0];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        tmo_d   = tmo_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (refill_req_i) begin
                    state_d = BURST;
                    addr_d  = start_adr;
                    beat_d  = 3'd0;
                    tmo_d   = 8'd0;
                end
            end
            BURST: begin
                if (abort) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (bus_ack_i) begin
                    addr_d = {addr_q[W-1:BW], idx_next, 2'b00};
                    beat_d = beat_q + 3'd1;
                    tmo_d  = 8'd0;
                    if (last_beat) begin
                        state_d = DONE;
                    end
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            // One quiet cycle so the cache's final refill cycle cannot retrigger a burst.
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            beat_q  <= 3'd0;
            tmo_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    assign bus_cyc_o = in_burst;
    assign bus_stb_o = in_burst;
    assign bus_adr_o = addr_q;
    assign bus_cti_o = in_burst ? (last_beat ? 3'b111 : 3'b010) : 3'b000;
    assign bus_bte_o = in_burst ? BURST_BTE : 2'b00;

    assign wradr_o = addr_q;
    assign wrdat_o = in_burst ? bus_dat_i : '0;
    assign we_o    = ack_ok;
    assign err_o   = err_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_mor1kx_icache_refill_ctrl.sv
// Directed bench for mor1kx_icache_refill_ctrl: 32 B line instance plus a 16 B line instance.
// Expected addresses follow MOR1KX_ICACHE_REFILL_CWF_EN when the macro is defined for the build.
module tb_mor1kx_icache_refill_ctrl;

    logic        clk;
    logic        rst;

    logic        refillReq;
    logic [31:0] reqAdr;
    logic [31:0] wrAdr, wrDat, busAdr, busDat;
    logic        we, err, busy, cyc, stb, busAck, busErr;
    logic [2:0]  cti;
    logic [1:0]  bte;

    logic        refillReq4;
    logic [31:0] reqAdr4;
    logic [31:0] wrAdr4, wrDat4, busAdr4, busDat4;
    logic        we4, err4, busy4, cyc4, stb4, busAck4, busErr4;
    logic [2:0]  cti4;
    logic [1:0]  bte4;

    int checkCount = 0;
    int errorCount = 0;

`ifdef MOR1KX_ICACHE_REFILL_CWF_EN
    localparam logic [1:0] EXP_BTE5 = 2'b10;
    localparam logic [1:0] EXP_BTE4 = 2'b01;
`else
    localparam logic [1:0] EXP_BTE5 = 2'b00;
    localparam logic [1:0] EXP_BTE4 = 2'b00;
`endif

    mor1kx_icache_refill_ctrl #(
        .OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(5), .TIMEOUT_CYCLES(255)
    ) dut (
        .clk(clk), .rst(rst),
        .refill_req_i(refillReq), .req_adr_i(reqAdr),
        .wradr_o(wrAdr), .wrdat_o(wrDat), .we_o(we), .err_o(err), .busy_o(busy),
        .bus_adr_o(busAdr), .bus_cyc_o(cyc), .bus_stb_o(stb), .bus_cti_o(cti), .bus_bte_o(bte),
        .bus_dat_i(busDat), .bus_ack_i(busAck), .bus_err_i(busErr)
    );

    mor1kx_icache_refill_ctrl #(
        .OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(4), .TIMEOUT_CYCLES(255)
    ) dut4 (
        .clk(clk), .rst(rst),
        .refill_req_i(refillReq4), .req_adr_i(reqAdr4),
        .wradr_o(wrAdr4), .wrdat_o(wrDat4), .we_o(we4), .err_o(err4), .busy_o(busy4),
        .bus_adr_o(busAdr4), .bus_cyc_o(cyc4), .bus_stb_o(stb4), .bus_cti_o(cti4), .bus_bte_o(bte4),
        .bus_dat_i(busDat4), .bus_ack_i(busAck4), .bus_err_i(busErr4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected word address of beat k for a 32 B line burst starting at a given miss address
    function automatic logic [31:0] expAdr5(input logic [31:0] miss, input int k);
`ifdef MOR1KX_ICACHE_REFILL_CWF_EN
        return {miss[31:5], 5'((miss[4:0] & 5'h1C) + 5'(4 * k))};
`else
        return {miss[31:5], 5'(4 * k)};
`endif
    endfunction

    function automatic logic [31:0] expAdr4(input logic [31:0] miss, input int k);
`ifdef MOR1KX_ICACHE_REFILL_CWF_EN
        return {miss[31:4], 4'((miss[3:0] & 4'hC) + 4'(4 * k))};
`else
        return {miss[31:4], 4'(4 * k)};
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if ({cyc, stb, we, err, busy, cti, bte} !== 10'd0) begin
            errorCount++;
            $display("[TB] FAIL reset_ctrl32: got %b, expected 0", {cyc, stb, we, err, busy, cti, bte});
        end
        checkCount++;
        if ({wrAdr, busAdr} !== 64'd0) begin
            errorCount++;
            $display("[TB] FAIL reset_addr32: got %h, expected 0", {wrAdr, busAdr});
        end
        checkCount++;
        if ({cyc4, stb4, we4, err4, busy4, cti4, bte4, wrAdr4} !== 42'd0) begin
            errorCount++;
            $display("[TB] FAIL reset_dut16: got %h, expected 0", {cyc4, stb4, we4, err4, busy4, cti4, bte4, wrAdr4});
        end
        rst = 1'b0;
    endtask

    task automatic test_burst_zero_wait();
        int weCount = 0;
        logic [31:0] miss = 32'h0000_1014;
        reqAdr = miss;
        refillReq = 1'b1;
        #1;
        checkCount++;
        if (busy !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL burst_idle_busy: got %b, expected 0", busy);
        end
        @(posedge clk); #1;
        refillReq = 1'b0;
        for (int i = 0; i < 8; i++) begin
            busAck = 1'b1;
            busDat = 32'hA5A5_0000 + 32'(i);
            #1;
            checkCount++;
            if (busAdr !== expAdr5(miss, i) || wrAdr !== expAdr5(miss, i)) begin
                errorCount++;
                $display("[TB] FAIL burst_adr beat %0d: got %h/%h, expected %h", i, busAdr, wrAdr, expAdr5(miss, i));
            end
            checkCount++;
            if ({cyc, stb, we, busy} !== 4'b1111) begin
                errorCount++;
                $display("[TB] FAIL burst_ctrl beat %0d: got %b, expected 1111", i, {cyc, stb, we, busy});
            end
            checkCount++;
            if (wrDat !== busDat) begin
                errorCount++;
                $display("[TB] FAIL burst_dat beat %0d: got %h, expected %h", i, wrDat, busDat);
            end
            checkCount++;
            if (cti !== ((i == 7) ? 3'b111 : 3'b010) || bte !== EXP_BTE5) begin
                errorCount++;
                $display("[TB] FAIL burst_cti beat %0d: got %b/%b, expected %b/%b", i, cti, bte,
                         (i == 7) ? 3'b111 : 3'b010, EXP_BTE5);
            end
            if (we) weCount++;
            @(posedge clk); #1;
        end
        busAck = 1'b0;
        refillReq = 1'b1;
        #1;
        checkCount++;
        if ({busy, cyc, stb, we} !== 4'b1000) begin
            errorCount++;
            $display("[TB] FAIL burst_done: got %b, expected 1000", {busy, cyc, stb, we});
        end
        @(posedge clk); #1;
        refillReq = 1'b0;
        #1;
        checkCount++;
        if ({busy, cyc} !== 2'b00) begin
            errorCount++;
            $display("[TB] FAIL burst_idle_after: got %b, expected 00", {busy, cyc});
        end
        @(posedge clk); #1;
        checkCount++;
        if (cyc !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL done_ignores_req: got cyc %b, expected 0", cyc);
        end
        checkCount++;
        if (weCount !== 8) begin
            errorCount++;
            $display("[TB] FAIL burst_we_count: got %0d, expected 8", weCount);
        end
    endtask

    task automatic test_slow_ack();
        int beat;
        logic [31:0] miss = 32'h0000_2008;
        reqAdr4 = miss;
        refillReq4 = 1'b1;
        @(posedge clk); #1;
        refillReq4 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            beat = c / 2;
            busAck4 = (c % 2) == 1;
            busDat4 = 32'h5A00_0000 + 32'(c);
            #1;
            checkCount++;
            if (busAdr4 !== expAdr4(miss, beat) || we4 !== busAck4) begin
                errorCount++;
                $display("[TB] FAIL slow_adr_we cycle %0d: got %h/%b, expected %h/%b", c, busAdr4, we4,
                         expAdr4(miss, beat), busAck4);
            end
            checkCount++;
            if (cti4 !== ((beat == 3) ? 3'b111 : 3'b010) || bte4 !== EXP_BTE4 || cyc4 !== 1'b1) begin
                errorCount++;
                $display("[TB] FAIL slow_cti cycle %0d: got %b/%b/%b", c, cti4, bte4, cyc4);
            end
            if (busAck4) begin
                checkCount++;
                if (wrDat4 !== 32'h5A00_0000 + 32'(c)) begin
                    errorCount++;
                    $display("[TB] FAIL slow_dat cycle %0d: got %h, expected %h", c, wrDat4, 32'h5A00_0000 + 32'(c));
                end
            end
            @(posedge clk); #1;
        end
        busAck4 = 1'b0;
        #1;
        checkCount++;
        if ({busy4, cyc4} !== 2'b10) begin
            errorCount++;
            $display("[TB] FAIL slow_done: got %b, expected 10", {busy4, cyc4});
        end
        @(posedge clk); #1;
        checkCount++;
        if (busy4 !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL slow_idle: got %b, expected 0", busy4);
        end
    endtask

    task automatic test_bus_error();
        int weCount = 0;
        reqAdr = 32'h0000_3000;
        refillReq = 1'b1;
        @(posedge clk); #1;
        refillReq = 1'b0;
        for (int i = 0; i < 2; i++) begin
            busAck = 1'b1;
            busDat = 32'hE000_0000 + 32'(i);
            #1;
            if (we) weCount++;
            @(posedge clk); #1;
        end
        busAck = 1'b1;
        busErr = 1'b1;
        #1;
        checkCount++;
        if ({cyc, we, err} !== 3'b100) begin
            errorCount++;
            $display("[TB] FAIL err_beat: got cyc/we/err %b, expected 100", {cyc, we, err});
        end
        if (we) weCount++;
        @(posedge clk); #1;
        busAck = 1'b0;
        busErr = 1'b0;
        #1;
        checkCount++;
        if ({err, cyc, stb, busy} !== 4'b1000) begin
            errorCount++;
            $display("[TB] FAIL err_pulse: got err/cyc/stb/busy %b, expected 1000", {err, cyc, stb, busy});
        end
        @(posedge clk); #1;
        checkCount++;
        if ({err, cyc} !== 2'b00) begin
            errorCount++;
            $display("[TB] FAIL err_one_cycle: got %b, expected 00", {err, cyc});
        end
        checkCount++;
        if (weCount !== 2) begin
            errorCount++;
            $display("[TB] FAIL err_we_count: got %0d, expected 2", weCount);
        end
    endtask

    task automatic test_timeout();
        int cycHigh = 0;
        int weSeen = 0;
        int errEarly = 0;
        reqAdr = 32'h0000_4000;
        refillReq = 1'b1;
        @(posedge clk); #1;
        refillReq = 1'b0;
        for (int i = 0; i < 255; i++) begin
            #1;
            if (cyc) cycHigh++;
            if (we) weSeen++;
            if (err) errEarly++;
            @(posedge clk); #1;
        end
        #1;
        checkCount++;
        if ({err, cyc} !== 2'b10) begin
            errorCount++;
            $display("[TB] FAIL timeout_err: got err/cyc %b, expected 10", {err, cyc});
        end
        checkCount++;
        if (cycHigh !== 255 || weSeen !== 0 || errEarly !== 0) begin
            errorCount++;
            $display("[TB] FAIL timeout_window: got cyc %0d we %0d err %0d, expected 255 0 0",
                     cycHigh, weSeen, errEarly);
        end
        @(posedge clk); #1;
        checkCount++;
        if (err !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL timeout_pulse_len: got %b, expected 0", err);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] miss = 32'h0000_6010;
        reqAdr = 32'h0000_5000;
        refillReq = 1'b1;
        @(posedge clk); #1;
        refillReq = 1'b0;
        busAck = 1'b1;
        busDat = 32'h1111_0000;
        #1;
        checkCount++;
        if (we !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL rst_first_beat: got we %b, expected 1", we);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkCount++;
        if ({cyc, stb, we, err, busy} !== 5'b00000) begin
            errorCount++;
            $display("[TB] FAIL rst_mid_burst: got %b, expected 00000", {cyc, stb, we, err, busy});
        end
        busAck = 1'b0;
        reqAdr = miss;
        refillReq = 1'b1;
        @(posedge clk); #1;
        refillReq = 1'b0;
        #1;
        checkCount++;
        if (cyc !== 1'b1 || busAdr !== expAdr5(miss, 0)) begin
            errorCount++;
            $display("[TB] FAIL rst_fresh_burst: got cyc %b adr %h, expected 1 %h", cyc, busAdr, expAdr5(miss, 0));
        end
        for (int i = 0; i < 8; i++) begin
            busAck = 1'b1;
            @(posedge clk); #1;
        end
        busAck = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if (busy !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL rst_drain_idle: got %b, expected 0", busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        refillReq = 1'b0; reqAdr = '0; busDat = '0; busAck = 1'b0; busErr = 1'b0;
        refillReq4 = 1'b0; reqAdr4 = '0; busDat4 = '0; busAck4 = 1'b0; busErr4 = 1'b0;
        test_reset();
        @(posedge clk); #1;
        test_burst_zero_wait();
        test_slow_ack();
        test_bus_error();
        test_timeout();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
